// File: rtl/hello_pkg.sv
// Shared HELLO routing definitions: TDEST codes and the demux packet-FSM encoding.
package hello_pkg;

  localparam int NUM_PORTS = 3;

  typedef enum logic [1:0] {
    ROUTE_FIFO = 2'd0,
    ROUTE_ADI  = 2'd1,
    ROUTE_DMA  = 2'd2,
    ROUTE_DROP = 2'd3
  } route_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } pkt_state_e;

  function automatic logic is_drop(input logic [1:0] dest);
    return dest == ROUTE_DROP;
  endfunction

endpackage

// File: rtl/axis_pipe_reg.sv
// Single-stage AXIS output register: holds one beat plus its destination port.
// A load and a drain in the same cycle replace the beat and keep valid high.
module axis_pipe_reg #(
  parameter int DATA_W = 64,
  parameter int USER_W = 32,
  parameter int PORT_W = 2
) (
  input  logic              AXIS_ACLK,
  input  logic              AXIS_ARESETN,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [USER_W-1:0] in_user,
  input  logic [PORT_W-1:0] in_port,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [USER_W-1:0] out_user,
  output logic [PORT_W-1:0] out_port
);

  logic load;

  // Space is available when empty or when the held beat leaves this cycle.
  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready;

  // Payload only changes on a load, so it stays stable while stalled.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_user  <= '0;
      out_port  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_last  <= in_last;
      out_user  <= in_user;
      out_port  <= in_port;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/hello_demux.sv
// HELLO demux: routes AXIS packets from the router to one of three masters by
// first-beat TDEST, discards TDEST=3 packets, and counts packets per port.
module hello_demux
  import hello_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int USER_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              AXIS_ACLK,
  input  logic              AXIS_ARESETN,
  input  logic              S_AXIS_TVALID,
  output logic              S_AXIS_TREADY,
  input  logic [DATA_W-1:0] S_AXIS_TDATA,
  input  logic              S_AXIS_TLAST,
  input  logic [USER_W-1:0] S_AXIS_TUSER,
  input  logic [1:0]        S_AXIS_TDEST,
  output logic              M0_AXIS_TVALID,
  input  logic              M0_AXIS_TREADY,
  output logic [DATA_W-1:0] M0_AXIS_TDATA,
  output logic              M0_AXIS_TLAST,
  output logic [USER_W-1:0] M0_AXIS_TUSER,
  output logic              M1_AXIS_TVALID,
  input  logic              M1_AXIS_TREADY,
  output logic [DATA_W-1:0] M1_AXIS_TDATA,
  output logic              M1_AXIS_TLAST,
  output logic [USER_W-1:0] M1_AXIS_TUSER,
  output logic              M2_AXIS_TVALID,
  input  logic              M2_AXIS_TREADY,
  output logic [DATA_W-1:0] M2_AXIS_TDATA,
  output logic              M2_AXIS_TLAST,
  output logic [USER_W-1:0] M2_AXIS_TUSER,
  output logic [CNT_W-1:0]  PKT_CNT0,
  output logic [CNT_W-1:0]  PKT_CNT1,
  output logic [CNT_W-1:0]  PKT_CNT2,
  output logic [CNT_W-1:0]  DROP_CNT
);

  pkt_state_e                          state;
  logic [1:0]                          dest_q;
  logic [1:0]                          dest_eff;
  logic                                s_acc;
  logic                                s_drop;
  logic                                pipe_in_valid;
  logic                                pipe_in_ready;
  logic                                out_valid;
  logic                                out_last;
  logic [DATA_W-1:0]                   out_data;
  logic [USER_W-1:0]                   out_user;
  logic [1:0]                          out_port;
  logic                                sel_ready;
  logic [NUM_PORTS-1:0]                m_tready;
  logic [NUM_PORTS-1:0]                m_tvalid;
  logic [NUM_PORTS-1:0][CNT_W-1:0]     pkt_cnt;
  logic [CNT_W-1:0]                    drop_cnt;

  // First beat routes by its own TDEST; later beats follow the held route.
  assign dest_eff      = (state == ST_IDLE) ? S_AXIS_TDEST : dest_q;
  assign s_drop        = is_drop(dest_eff);
  assign S_AXIS_TREADY = pipe_in_ready;
  assign s_acc         = S_AXIS_TVALID && S_AXIS_TREADY;
  assign pipe_in_valid = S_AXIS_TVALID && !s_drop;

  assign m_tready = {M2_AXIS_TREADY, M1_AXIS_TREADY, M0_AXIS_TREADY};

  // Ready of whichever port currently owns the output register.
  always_comb begin
    sel_ready = 1'b0;
    case (out_port)
      2'd0:    sel_ready = m_tready[0];
      2'd1:    sel_ready = m_tready[1];
      2'd2:    sel_ready = m_tready[2];
      default: sel_ready = 1'b0;
    endcase
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_vld
    assign m_tvalid[p] = out_valid && (out_port == 2'(p));
  end

  axis_pipe_reg #(
    .DATA_W (DATA_W),
    .USER_W (USER_W),
    .PORT_W (2)
  ) u_pipe (
    .AXIS_ACLK    (AXIS_ACLK),
    .AXIS_ARESETN (AXIS_ARESETN),
    .in_valid     (pipe_in_valid),
    .in_ready     (pipe_in_ready),
    .in_data      (S_AXIS_TDATA),
    .in_last      (S_AXIS_TLAST),
    .in_user      (S_AXIS_TUSER),
    .in_port      (dest_eff),
    .out_valid    (out_valid),
    .out_ready    (sel_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_user     (out_user),
    .out_port     (out_port)
  );

  // Packet FSM: latch the route on a non-last first beat, release on TLAST.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state  <= ST_IDLE;
      dest_q <= 2'd0;
    end else if (s_acc) begin
      case (state)
        ST_IDLE: begin
          if (!S_AXIS_TLAST) begin
            dest_q <= S_AXIS_TDEST;
            state  <= is_drop(S_AXIS_TDEST) ? ST_DROP : ST_PASS;
          end
        end
        default: begin
          if (S_AXIS_TLAST) state <= ST_IDLE;
        end
      endcase
    end
  end

  // Status counters: completed packets per master, discarded packets; all wrap.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++)
        if (m_tvalid[p] && m_tready[p] && out_last) pkt_cnt[p] <= pkt_cnt[p] + CNT_W'(1);
      if (s_acc && s_drop && S_AXIS_TLAST) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  assign M0_AXIS_TVALID = m_tvalid[0];
  assign M1_AXIS_TVALID = m_tvalid[1];
  assign M2_AXIS_TVALID = m_tvalid[2];
  assign M0_AXIS_TDATA  = out_data;
  assign M1_AXIS_TDATA  = out_data;
  assign M2_AXIS_TDATA  = out_data;
  assign M0_AXIS_TLAST  = out_last;
  assign M1_AXIS_TLAST  = out_last;
  assign M2_AXIS_TLAST  = out_last;
  assign M0_AXIS_TUSER  = out_user;
  assign M1_AXIS_TUSER  = out_user;
  assign M2_AXIS_TUSER  = out_user;
  assign PKT_CNT0       = pkt_cnt[0];
  assign PKT_CNT1       = pkt_cnt[1];
  assign PKT_CNT2       = pkt_cnt[2];
  assign DROP_CNT       = drop_cnt;

endmodule

// File: tb/tb_hello_demux.sv
// Bench for hello_demux: directed scenarios plus randomized traffic, checked
// against a packet-level reference model with per-port expected-beat queues.
module tb_hello_demux;

  typedef struct {
    logic [63:0] d;
    logic        l;
    logic [31:0] u;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [63:0] s_tdata = '0;
  logic        s_tlast = 1'b0;
  logic [31:0] s_tuser = '0;
  logic [1:0]  s_tdest = '0;
  logic [2:0]  m_rdy = 3'b111;
  logic        m0_v, m1_v, m2_v, m0_l, m1_l, m2_l;
  logic [63:0] m0_d, m1_d, m2_d;
  logic [31:0] m0_u, m1_u, m2_u;
  logic [15:0] pkt0, pkt1, pkt2, dropc;

  logic [2:0]  mv;
  logic [63:0] md [3];
  logic        ml [3];
  logic [31:0] mu [3];
  assign mv = {m2_v, m1_v, m0_v};
  assign md[0] = m0_d; assign md[1] = m1_d; assign md[2] = m2_d;
  assign ml[0] = m0_l; assign ml[1] = m1_l; assign ml[2] = m2_l;
  assign mu[0] = m0_u; assign mu[1] = m1_u; assign mu[2] = m2_u;

  hello_demux dut (
    .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n),
    .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready), .S_AXIS_TDATA(s_tdata),
    .S_AXIS_TLAST(s_tlast), .S_AXIS_TUSER(s_tuser), .S_AXIS_TDEST(s_tdest),
    .M0_AXIS_TVALID(m0_v), .M0_AXIS_TREADY(m_rdy[0]), .M0_AXIS_TDATA(m0_d),
    .M0_AXIS_TLAST(m0_l), .M0_AXIS_TUSER(m0_u),
    .M1_AXIS_TVALID(m1_v), .M1_AXIS_TREADY(m_rdy[1]), .M1_AXIS_TDATA(m1_d),
    .M1_AXIS_TLAST(m1_l), .M1_AXIS_TUSER(m1_u),
    .M2_AXIS_TVALID(m2_v), .M2_AXIS_TREADY(m_rdy[2]), .M2_AXIS_TDATA(m2_d),
    .M2_AXIS_TLAST(m2_l), .M2_AXIS_TUSER(m2_u),
    .PKT_CNT0(pkt0), .PKT_CNT1(pkt1), .PKT_CNT2(pkt2), .DROP_CNT(dropc)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  beat_t       exp_q [3][$];
  logic [15:0] m_pkt [3];
  logic [15:0] m_drop;
  bit          in_pkt;
  logic [1:0]  cur_dest;
  bit          mon_en;
  bit          fwd_pend;
  int          fwd_port;
  beat_t       fwd_beat;
  bit          stall [3];
  beat_t       held [3];
  beat_t       e;
  logic [1:0]  d_m;

  task automatic model_clear();
    for (int p = 0; p < 3; p++) begin
      exp_q[p].delete();
      m_pkt[p] = '0;
      stall[p] = 0;
    end
    m_drop = '0; in_pkt = 0; cur_dest = '0; fwd_pend = 0;
  endtask

  // Negedge monitor: handshake outcomes for the coming edge are settled here.
  always @(negedge clk) begin
    if (mon_en) begin
      if (fwd_pend) begin
        check("latency_valid", 64'(mv[fwd_port]), 64'd1);
        check("latency_data", md[fwd_port], fwd_beat.d);
        fwd_pend = 0;
      end
      check("single_valid", 64'($countones(mv) <= 1), 64'd1);
      for (int p = 0; p < 3; p++) begin
        if (stall[p]) begin
          check("stall_valid", 64'(mv[p]), 64'd1);
          check("stall_data", md[p], held[p].d);
          check("stall_last", 64'(ml[p]), 64'(held[p].l));
          check("stall_user", 64'(mu[p]), 64'(held[p].u));
        end
        stall[p] = mv[p] && !m_rdy[p];
        held[p]  = '{d: md[p], l: ml[p], u: mu[p]};
        if (mv[p] && m_rdy[p]) begin
          if (exp_q[p].size() == 0) begin
            check($sformatf("unexpected_beat_m%0d", p), 64'd1, 64'd0);
          end else begin
            e = exp_q[p].pop_front();
            check($sformatf("m%0d_data", p), md[p], e.d);
            check($sformatf("m%0d_last", p), 64'(ml[p]), 64'(e.l));
            check($sformatf("m%0d_user", p), 64'(mu[p]), 64'(e.u));
          end
        end
      end
      if (s_tvalid && s_tready) begin
        d_m = in_pkt ? cur_dest : s_tdest;
        cur_dest = d_m;
        in_pkt = !s_tlast;
        if (d_m == 2'd3) begin
          if (s_tlast) m_drop = m_drop + 16'd1;
        end else begin
          exp_q[d_m].push_back('{d: s_tdata, l: s_tlast, u: s_tuser});
          if (s_tlast) m_pkt[d_m] = m_pkt[d_m] + 16'd1;
          fwd_pend = 1; fwd_port = int'(d_m);
          fwd_beat = '{d: s_tdata, l: s_tlast, u: s_tuser};
        end
      end
    end
  end

  // ---------------- master ready driver ----------------
  int   rdy_mode = 0;
  logic tog = 1'b0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       m_rdy = 3'($urandom);
      2:       begin tog = ~tog; m_rdy = {2'b11, tog}; end
      default: m_rdy = 3'b111;
    endcase
  end

  // ---------------- stimulus tasks ----------------
  task automatic send(input logic [1:0] dest, input logic [63:0] d, input logic l, input logic [31:0] u);
    int  n = 0;
    bit  acc = 0;
    s_tvalid = 1'b1; s_tdest = dest; s_tdata = d; s_tlast = l; s_tuser = u;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = s_tvalid && s_tready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) check("send_timeout", 64'd0, 64'd1);
    s_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input logic [1:0] dest, input int len, input logic [1:0] later_dest);
    for (int i = 0; i < len; i++)
      send(i == 0 ? dest : later_dest, {$urandom, $urandom}, (i == len - 1), $urandom);
  endtask

  task automatic drain();
    int n = 0;
    s_tvalid = 1'b0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() != 0 || mv != 3'b000) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) check("drain_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_pkt0"}, 64'(pkt0), 64'(m_pkt[0]));
    check({tag, "_pkt1"}, 64'(pkt1), 64'(m_pkt[1]));
    check({tag, "_pkt2"}, 64'(pkt2), 64'(m_pkt[2]));
    check({tag, "_drop"}, 64'(dropc), 64'(m_drop));
  endtask

  task automatic do_reset();
    mon_en = 0;
    rst_n = 1'b0;
    s_tvalid = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", 64'(mv), 64'd0);
    check("rst_m_data", m0_d, 64'd0);
    check("rst_m_last", 64'(m1_l), 64'd0);
    check("rst_m_user", 64'(m2_u), 64'd0);
    check("rst_cnt", 64'({pkt0, pkt1, pkt2, dropc}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_tready", 64'(s_tready), 64'd1);
    mon_en = 1;
  endtask

  initial begin
    mon_en = 0;
    model_clear();
    do_reset();

    // 4-beat packet to port 1, all ready
    rdy_mode = 0;
    send_pkt(2'd1, 4, 2'd1);
    drain();
    check("s1_pkt1", 64'(pkt1), 64'd1);
    check_counters("s1");

    // TDEST changes mid-packet; the first beat decides
    do_reset();
    send(2'd2, 64'h11, 1'b0, 32'h1);
    send(2'd0, 64'h22, 1'b0, 32'h2);
    send(2'd1, 64'h33, 1'b1, 32'h3);
    drain();
    check("s2_pkt2", 64'(pkt2), 64'd1);
    check("s2_pkt01", 64'({pkt0, pkt1}), 64'd0);

    // Toggling M0 ready with an 8-beat packet
    do_reset();
    rdy_mode = 2;
    send_pkt(2'd0, 8, 2'd3);
    drain();
    check("s3_pkt0", 64'(pkt0), 64'd1);
    rdy_mode = 0;

    // 5-beat discard followed by a single-beat packet to port 0
    do_reset();
    send_pkt(2'd3, 5, 2'd1);
    send(2'd0, 64'hABCD, 1'b1, 32'h5);
    drain();
    check("s4_drop", 64'(dropc), 64'd1);
    check("s4_pkt0", 64'(pkt0), 64'd1);

    // Reset during beat 2 of a 4-beat packet
    do_reset();
    send(2'd1, 64'h1, 1'b0, 32'h0);
    s_tvalid = 1'b1; s_tdest = 2'd1; s_tdata = 64'h2; s_tlast = 1'b0;
    do_reset();
    send(2'd2, 64'h77, 1'b1, 32'h9);
    drain();
    check("s5_pkt2", 64'(pkt2), 64'd1);
    check("s5_pkt1", 64'(pkt1), 64'd0);

    // Randomized traffic under random backpressure
    do_reset();
    rdy_mode = 1;
    for (int k = 0; k < 80; k++) begin
      send_pkt(2'($urandom), int'($urandom_range(1, 8)), 2'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    drain();
    check_counters("rand");
    rdy_mode = 0;

    // Counter wrap on port 2
    do_reset();
    for (int k = 0; k < 65535; k++) send(2'd2, 64'(k), 1'b1, 32'(k));
    drain();
    check("wrap_ffff", 64'(pkt2), 64'hFFFF);
    send(2'd2, 64'hFFFF, 1'b1, 32'h0);
    drain();
    check("wrap_zero", 64'(pkt2), 64'd0);
    check_counters("wrap");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hello_demux.md
HELLO_DEMUX -- requirements
Module: hello_demux

Interface
REQ-001 Parameter DATA_W, default 64: TDATA width on all ports.
REQ-002 Parameter USER_W, default 32: TUSER width on all ports.
REQ-003 Parameter CNT_W, default 16: width of each status counter.
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 AXIS_ACLK  in  1  sole clock; all state updates on rising edge.
REQ-006 AXIS_ARESETN  in  1  asynchronous active-low reset.
REQ-007 S_AXIS_TVALID/TREADY  in/out  1/1  upstream handshake from the HELLO router.
REQ-008 S_AXIS_TDATA  in  DATA_W  beat data.
REQ-009 S_AXIS_TLAST  in  1  last beat of packet.
REQ-010 S_AXIS_TUSER  in  USER_W  sideband, passed unchanged.
REQ-011 S_AXIS_TDEST  in  2  route: 0=srio_fifo, 1=adi chain, 2=srio_dma, 3=discard.
REQ-012 Mn_AXIS_TVALID/TREADY/TDATA/TLAST/TUSER, n=0..2  out/in/out/out/out  1/1/DATA_W/1/USER_W  one master port per TDEST value 0..2.
REQ-013 PKT_CNT0..2  out  CNT_W each  packets completed per master port.
REQ-014 DROP_CNT  out  CNT_W  packets discarded.

Function
REQ-015 The destination is sampled from S_AXIS_TDEST on the first beat of a packet and held until that packet's TLAST beat is accepted; TDEST on later beats is ignored.
REQ-016 The packet-level FSM has three states: IDLE (next beat is a first beat), PASS (mid-packet to a held port 0..2), and DROP (mid-packet discard).
REQ-017 In IDLE, an accepted beat with TLAST=0 moves the FSM to PASS, or to DROP when TDEST=3; an accepted beat with TLAST=1 keeps the FSM in IDLE.
REQ-018 In PASS or DROP, an accepted beat with TLAST=1 returns the FSM to IDLE; any other beat leaves the state unchanged.
REQ-019 Forwarded beats pass through one output register (data, last, user, port select, valid); the latency from S transfer to Mn_TVALID is exactly 1 cycle.
REQ-020 Only the selected Mn_AXIS_TVALID is asserted; the other two master ports hold TVALID=0.
REQ-021 All Mn_TDATA/TLAST/TUSER are driven from the shared output register.
REQ-022 S_AXIS_TREADY = !out_valid | Mn_TREADY(selected port), giving full throughput with back-to-back beats.
REQ-023 Beats destined for discard are accepted with S_AXIS_TREADY=1 regardless of master ready, but only while the output register is empty or draining in the same cycle.
REQ-024 Discarded beats never load the output register.
REQ-025 When a register load and a drain occur in the same cycle, the register takes the new beat and out_valid stays 1.
REQ-026 Once Mn_TVALID is asserted, TDATA/TLAST/TUSER/port stay stable until Mn_TREADY is asserted.
REQ-027 A packet of one beat (TLAST on the first beat) is routed by its own TDEST.
REQ-028 PKT_CNTn increments on an Mn transfer with TLAST=1.
REQ-029 DROP_CNT increments on an accepted discard beat with TLAST=1, including a single-beat discard packet in IDLE.
REQ-030 All counters wrap modulo 2^CNT_W with no saturation.
REQ-031 Packets on a master port keep their input order; beats are never reordered, duplicated or dropped, except for TDEST=3 packets.

Reset
REQ-032 When AXIS_ARESETN is asserted: FSM=IDLE, out_valid=0, all Mn_TVALID=0, output data/last/user registers=0, port select=0, all counters=0, and S_AXIS_TREADY=1 on the first cycle after release.
REQ-033 A reset asserted mid-packet discards the partial packet with no recovery; the next beat after release is treated as a first beat.

Structure
REQ-034 The TDEST codes (ROUTE_FIFO=0, ROUTE_ADI=1, ROUTE_DMA=2, ROUTE_DROP=3) and the FSM state encoding belong in a shared hello_pkg, which the router also uses.
REQ-035 The output register and its ready logic are implemented as one sub-module, axis_pipe_reg, instantiated once; the FSM, port decode and counters live at top level.

Verification
REQ-036 Scenario: 4-beat packet, TDEST=1, all TREADY=1 -> 4 beats appear on M1 only, with 1-cycle latency and no gaps; PKT_CNT1=1.
REQ-037 Scenario: 3-beat packet whose TDEST changes 2->0->1 across beats -> all 3 beats appear on M2; PKT_CNT2=1, PKT_CNT0=PKT_CNT1=0.
REQ-038 Scenario: M0_TREADY toggling 1010..., 8-beat packet to port 0 -> data matches the input sequence and TDATA is stable while stalled.
REQ-039 Scenario: 5-beat TDEST=3 packet, then a 1-beat TDEST=0 packet -> nothing is output during the discard, M0 receives 1 beat, DROP_CNT=1, PKT_CNT0=1.
REQ-040 Scenario: reset asserted on beat 2 of a 4-beat packet -> all outputs and counters read 0; the next packet after release is routed by its own first-beat TDEST.
REQ-041 Scenario: 65536 single-beat packets to port 2 -> PKT_CNT2 wraps to 0.
